// File: rtl/jit_pkg.sv
// Shared definitions for the JIT accelerator ALU: data width, op codes and
// the MAC burst-length decode.
package jit_pkg;

    localparam int JIT_DATA_W = 32;

    typedef enum logic [1:0] {
        JIT_OP_ADD = 2'b00,
        JIT_OP_SUB = 2'b01,
        JIT_OP_MUL = 2'b10,
        JIT_OP_MAC = 2'b11
    } jit_op_e;

    // Burst length code 00/01/10/11 maps to 1/2/4/8 pairs.
    function automatic logic [3:0] jit_burst_len(input logic [1:0] code);
        return 4'd1 << code;
    endfunction

endpackage

// File: rtl/jit_fifo.sv
// Output result buffer: power-of-two depth FIFO that accepts a push and a pop
// in the same cycle even when full. Reads as zero while empty.
module jit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_doPop  = pop & ~empty;
    assign w_doPush = push & (~full | w_doPop);

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jit_acc_alu.sv
// Two-stage stream ALU (ADD/SUB/MUL/MAC) joining operand streams A and B,
// with credit-based acceptance into an output FIFO so nothing is ever dropped.
module jit_acc_alu
    import jit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    output logic                  sA_tready,
    input  logic                  sA_tvalid,
    input  logic [JIT_DATA_W-1:0] sA_tdata,
    output logic                  sB_tready,
    input  logic                  sB_tvalid,
    input  logic [JIT_DATA_W-1:0] sB_tdata,
    input  logic                  mC_tready,
    output logic                  mC_tvalid,
    output logic [JIT_DATA_W-1:0] mC_tdata,
    input  logic [3:0]            CONF,
    output logic                  BUSY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_accept;
    logic                  w_inBurst;
    logic                  w_last;
    jit_op_e               w_effOp;
    logic [3:0]            w_effLen;
    logic [JIT_DATA_W-1:0] w_prod;
    logic [JIT_DATA_W-1:0] w_macSum;
    logic [JIT_DATA_W-1:0] w_result;
    logic [JIT_DATA_W-1:0] w_fifoDout;

    logic                  r_s1Valid;
    logic                  r_s1Last;
    jit_op_e               r_s1Op;
    logic [JIT_DATA_W-1:0] r_s1A;
    logic [JIT_DATA_W-1:0] r_s1B;
    logic [3:0]            r_burstCnt;
    logic [3:0]            r_burstLen;
    logic [3:0]            r_macCnt;
    logic [JIT_DATA_W-1:0] r_acc;

    assign w_pop = mC_tvalid & mC_tready;

    // Credit: FIFO occupancy plus stage 1 must stay below depth, counting a pop this cycle.
    always_comb begin
        w_credit = ~w_full | w_pop;
        if (r_s1Valid) begin
            w_credit = w_pop ? ~w_full : (w_count < CW'(FIFO_DEPTH - 1));
        end
    end

    assign sA_tready = sA_tvalid & sB_tvalid & w_credit & ~ARESET;
    assign sB_tready = sA_tready;
    assign w_accept  = sA_tready;

    // While a MAC burst is open, CONF is ignored and the latched length rules.
    assign w_inBurst = (r_burstCnt != 4'd0);
    assign w_effOp   = w_inBurst ? JIT_OP_MAC : jit_op_e'(CONF[1:0]);
    assign w_effLen  = w_inBurst ? r_burstLen : jit_burst_len(CONF[3:2]);
    assign w_last    = ((r_burstCnt + 4'd1) == w_effLen);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_burstCnt <= 4'd0;
            r_burstLen <= 4'd1;
        end else if (w_accept && (w_effOp == JIT_OP_MAC)) begin
            if (!w_inBurst) begin
                r_burstLen <= w_effLen;
            end
            r_burstCnt <= w_last ? 4'd0 : r_burstCnt + 4'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            r_s1Op    <= JIT_OP_ADD;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Last <= w_last;
                r_s1Op   <= w_effOp;
                r_s1A    <= sA_tdata;
                r_s1B    <= sB_tdata;
            end
        end
    end

    assign w_prod   = r_s1A * r_s1B;
    assign w_macSum = r_acc + w_prod;

    always_comb begin
        w_result = r_s1A + r_s1B;
        case (r_s1Op)
            JIT_OP_ADD: w_result = r_s1A + r_s1B;
            JIT_OP_SUB: w_result = r_s1A - r_s1B;
            JIT_OP_MUL: w_result = w_prod;
            JIT_OP_MAC: w_result = w_macSum;
            default:    w_result = r_s1A + r_s1B;
        endcase
    end

    // Only the final pair of a MAC burst produces a result.
    assign w_push = r_s1Valid & ((r_s1Op != JIT_OP_MAC) | r_s1Last);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_acc    <= '0;
            r_macCnt <= 4'd0;
        end else if (r_s1Valid && (r_s1Op == JIT_OP_MAC)) begin
            if (r_s1Last) begin
                r_acc    <= '0;
                r_macCnt <= 4'd0;
            end else begin
                r_acc    <= w_macSum;
                r_macCnt <= r_macCnt + 4'd1;
            end
        end
    end

    jit_fifo #(
        .WIDTH (JIT_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_result),
        .dout  (w_fifoDout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign mC_tvalid = ~w_empty;
    assign mC_tdata  = w_fifoDout;
    assign BUSY      = r_s1Valid | ~w_empty | (r_macCnt != 4'd0) | w_inBurst;

endmodule

// File: tb/tb_jit_acc_alu.sv
// Scoreboard bench for jit_acc_alu: directed vectors push expected results,
// an independent monitor pops and compares every output transfer.
module tb_jit_acc_alu;

    localparam int FIFO_DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        sA_tready, sB_tready;
    logic        sA_tvalid = 1'b0, sB_tvalid = 1'b0;
    logic [31:0] sA_tdata = '0, sB_tdata = '0;
    logic        mC_tready = 1'b1;
    logic        mC_tvalid;
    logic [31:0] mC_tdata;
    logic [3:0]  CONF = 4'b0000;
    logic        BUSY;

    int checks = 0;
    int failures = 0;
    int outCnt = 0;
    int idx = 0;
    int accCnt = 0;
    int xferCnt = 0;
    int outSnap = 0;

    logic [31:0] expQ[$];
    logic [31:0] monExp;
    logic [31:0] vecA[16];
    logic [31:0] vecB[16];
    logic [31:0] vecE[16];
    logic [3:0]  vecConf[16];
    bit          vecOut[16];

    jit_acc_alu #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .sA_tready (sA_tready),
        .sA_tvalid (sA_tvalid),
        .sA_tdata  (sA_tdata),
        .sB_tready (sB_tready),
        .sB_tvalid (sB_tvalid),
        .sB_tdata  (sB_tdata),
        .mC_tready (mC_tready),
        .mC_tvalid (mC_tvalid),
        .mC_tdata  (mC_tdata),
        .CONF      (CONF),
        .BUSY      (BUSY)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] conf, input bit out, input logic [31:0] e);
        vecA[i] = a;
        vecB[i] = b;
        vecConf[i] = conf;
        vecOut[i] = out;
        vecE[i] = e;
    endtask

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge ACLK) begin
        if (!ARESET && mC_tvalid && mC_tready) begin
            outCnt++;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", mC_tdata);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("scoreboard", mC_tdata, monExp);
            end
        end
    end

    // Offers vectors idx..last-1 back to back for ncyc cycles, pushing expectations on accept.
    task automatic applyStimulus(input int ncyc, input int last);
        bit acc;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < last) begin
                sA_tvalid = 1'b1;
                sB_tvalid = 1'b1;
                sA_tdata  = vecA[idx];
                sB_tdata  = vecB[idx];
                CONF      = vecConf[idx];
            end else begin
                sA_tvalid = 1'b0;
                sB_tvalid = 1'b0;
            end
            @(negedge ACLK);
            acc = sA_tready;
            if (mC_tvalid && mC_tready) xferCnt++;
            if (acc) begin
                accCnt++;
                if (vecOut[idx]) expQ.push_back(vecE[idx]);
            end
            @(posedge ACLK);
            #1;
            if (acc) idx++;
        end
        sA_tvalid = 1'b0;
        sB_tvalid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge ACLK);
            n++;
        end
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("drain_queue_empty", expQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state, with both operand streams offering data.
        repeat (2) @(posedge ACLK);
        #1;
        sA_tvalid = 1'b1;
        sB_tvalid = 1'b1;
        #1;
        checkOutput("reset_sA_tready", sA_tready, 0);
        checkOutput("reset_sB_tready", sB_tready, 0);
        checkOutput("reset_mC_tvalid", mC_tvalid, 0);
        checkOutput("reset_mC_tdata", mC_tdata, 0);
        checkOutput("reset_busy", BUSY, 0);
        sA_tvalid = 1'b0;
        sB_tvalid = 1'b0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        // ADD latency: result visible exactly two cycles after the accept edge.
        idx = 0; accCnt = 0;
        setVec(0, 32'd5, 32'd7, 4'b0000, 1'b1, 32'd12);
        applyStimulus(1, 1);
        checkOutput("add_accepted", accCnt, 1);
        @(negedge ACLK);
        checkOutput("add_valid_after_1", mC_tvalid, 0);
        checkOutput("add_busy", BUSY, 1);
        @(negedge ACLK);
        checkOutput("add_valid_after_2", mC_tvalid, 1);
        checkOutput("add_data", mC_tdata, 32'd12);
        @(posedge ACLK);
        #1;
        waitDrain();

        // Mixed ops changing every pair, including wraparound cases.
        idx = 0; accCnt = 0;
        setVec(0, 32'd3, 32'd5, 4'b0001, 1'b1, 32'hFFFF_FFFE);
        setVec(1, 32'd6, 32'd7, 4'b0010, 1'b1, 32'd42);
        setVec(2, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 32'd0);
        setVec(3, 32'd100, 32'd1, 4'b0001, 1'b1, 32'd99);
        setVec(4, 32'h0001_0000, 32'h0001_0000, 4'b0010, 1'b1, 32'd0);
        applyStimulus(5, 5);
        checkOutput("mixed_no_bubble", accCnt, 5);
        waitDrain();

        // MAC length 4; CONF on pair 3 must be ignored mid-burst.
        idx = 0;
        setVec(0, 32'd1, 32'd2, 4'b1011, 1'b0, 32'd0);
        setVec(1, 32'd3, 32'd4, 4'b1011, 1'b0, 32'd0);
        setVec(2, 32'd5, 32'd6, 4'b0000, 1'b0, 32'd0);
        setVec(3, 32'd7, 32'd8, 4'b1011, 1'b1, 32'd100);
        applyStimulus(3, 3);
        applyStimulus(3, 3);
        checkOutput("mac_no_early_output", mC_tvalid, 0);
        checkOutput("mac_busy_mid_burst", BUSY, 1);
        applyStimulus(1, 4);
        waitDrain();
        checkOutput("mac_busy_after", BUSY, 0);

        // New bursts pick up the current CONF; followed by a plain ADD.
        idx = 0; accCnt = 0;
        setVec(0, 32'd2, 32'd3, 4'b0111, 1'b0, 32'd0);
        setVec(1, 32'd4, 32'd5, 4'b0111, 1'b1, 32'd26);
        setVec(2, 32'd9, 32'd9, 4'b0011, 1'b1, 32'd81);
        setVec(3, 32'd10, 32'd3, 4'b0000, 1'b1, 32'd13);
        applyStimulus(4, 4);
        checkOutput("mac_chain_accepts", accCnt, 4);
        waitDrain();

        // Join: A alone never handshakes.
        outSnap = outCnt;
        CONF = 4'b0000;
        sA_tdata = 32'd8;
        sB_tdata = 32'd9;
        sA_tvalid = 1'b1;
        sB_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("join_ready_low", sA_tready, 0);
            @(posedge ACLK);
            #1;
        end
        sB_tvalid = 1'b1;
        @(negedge ACLK);
        checkOutput("join_accept_a", sA_tready, 1);
        checkOutput("join_accept_b", sB_tready, 1);
        if (sA_tready) expQ.push_back(32'd17);
        @(posedge ACLK);
        #1;
        sA_tvalid = 1'b0;
        sB_tvalid = 1'b0;
        waitDrain();
        checkOutput("join_one_output", outCnt - outSnap, 1);

        // Backpressure: only FIFO_DEPTH MUL pairs get in while the sink stalls.
        mC_tready = 1'b0;
        idx = 0; accCnt = 0; xferCnt = 0;
        setVec(0, 32'd3, 32'd4, 4'b0010, 1'b1, 32'd12);
        setVec(1, 32'd5, 32'd6, 4'b0010, 1'b1, 32'd30);
        setVec(2, 32'd7, 32'd8, 4'b0010, 1'b1, 32'd56);
        setVec(3, 32'hFFFF_FFFF, 32'd2, 4'b0010, 1'b1, 32'hFFFF_FFFE);
        setVec(4, 32'h0001_0000, 32'h0001_0001, 4'b0010, 1'b1, 32'h0001_0000);
        setVec(5, 32'd12, 32'd13, 4'b0010, 1'b1, 32'd156);
        setVec(6, 32'd100, 32'd1000, 4'b0010, 1'b1, 32'd100000);
        setVec(7, 32'h8000_0001, 32'd3, 4'b0010, 1'b1, 32'h8000_0003);
        setVec(8, 32'd9, 32'd9, 4'b0010, 1'b1, 32'd81);
        setVec(9, 32'd11, 32'd11, 4'b0010, 1'b1, 32'd121);
        applyStimulus(12, 10);
        checkOutput("bp_accepted", accCnt, FIFO_DEPTH);
        checkOutput("bp_no_output", xferCnt, 0);
        sA_tdata = vecA[idx];
        sB_tdata = vecB[idx];
        sA_tvalid = 1'b1;
        sB_tvalid = 1'b1;
        #1;
        checkOutput("bp_ready_low", sA_tready, 0);
        checkOutput("bp_output_pending", mC_tvalid, 1);
        mC_tready = 1'b1;
        applyStimulus(40, 10);
        checkOutput("bp_all_accepted", idx, 10);
        waitDrain();

        // Full FIFO, sink ready, sources always valid: one in and one out every cycle.
        mC_tready = 1'b0;
        idx = 0; accCnt = 0;
        for (int i = 0; i < 12; i++) begin
            setVec(i, 32'd10 * (i + 1), i + 1, 4'b0000, 1'b1, 32'd11 * (i + 1));
        end
        applyStimulus(6, 12);
        checkOutput("tp_fill_accepts", accCnt, FIFO_DEPTH);
        mC_tready = 1'b1;
        accCnt = 0; xferCnt = 0;
        applyStimulus(8, 12);
        checkOutput("tp_accepts_per_cycle", accCnt, 8);
        checkOutput("tp_outputs_per_cycle", xferCnt, 8);
        waitDrain();

        // Reset in the middle of a MAC burst with a result still buffered.
        mC_tready = 1'b0;
        idx = 0;
        setVec(0, 32'd6, 32'd7, 4'b0010, 1'b1, 32'd42);
        setVec(1, 32'd1, 32'd1, 4'b1011, 1'b0, 32'd0);
        setVec(2, 32'd2, 32'd2, 4'b1011, 1'b0, 32'd0);
        applyStimulus(3, 3);
        applyStimulus(2, 3);
        checkOutput("pre_reset_valid", mC_tvalid, 1);
        checkOutput("pre_reset_busy", BUSY, 1);
        sA_tvalid = 1'b1;
        sB_tvalid = 1'b1;
        ARESET = 1'b1;
        #1;
        checkOutput("midreset_sA_tready", sA_tready, 0);
        checkOutput("midreset_sB_tready", sB_tready, 0);
        checkOutput("midreset_mC_tvalid", mC_tvalid, 0);
        checkOutput("midreset_mC_tdata", mC_tdata, 0);
        checkOutput("midreset_busy", BUSY, 0);
        expQ.delete();
        sA_tvalid = 1'b0;
        sB_tvalid = 1'b0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        mC_tready = 1'b1;
        idx = 0; accCnt = 0;
        setVec(0, 32'd2, 32'd3, 4'b0011, 1'b1, 32'd6);
        applyStimulus(1, 1);
        checkOutput("post_reset_accept", accCnt, 1);
        waitDrain();
        checkOutput("post_reset_busy", BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
